// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the 8259A-style interrupt controller.
//   init_state_e  : initialisation-word sequencer states
//   inta_phase_e  : interrupt-acknowledge phase tracking
//   OCW2_*        : OCW2 command codes (D[7:5])
//   ADDR_* / CMD_*: register-address decode (A0 and D[4:3])
//   top_isr()     : highest-priority set bit of an 8-bit vector under rotation
package pic_pkg;

  typedef enum logic [1:0] {
    INIT_READY = 2'd0,
    INIT_ICW2  = 2'd1,
    INIT_ICW3  = 2'd2,
    INIT_ICW4  = 2'd3
  } init_state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_ACK1 = 2'd1,
    PH_ACK2 = 2'd2
  } inta_phase_e;

  localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;

  localparam logic       ADDR_CMD  = 1'b0;
  localparam logic       ADDR_DATA = 1'b1;
  localparam logic [1:0] CMD_OCW2  = 2'b00;
  localparam logic [1:0] CMD_OCW3  = 2'b01;

  localparam logic [2:0] SPURIOUS_IR  = 3'd7;
  localparam logic [2:0] FIXED_LOWEST = 3'd7;

  // Returns {found, index} of the highest-priority set bit; priority starts
  // at lowest+1 and wraps, so lowest=7 gives the fixed IR0-first order.
  function automatic logic [3:0] top_isr(input logic [7:0] vec, input logic [2:0] lowest);
    logic [2:0] idx;
    logic [3:0] res;
    res = 4'b0;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = lowest + 3'(i + 1);
      if (!res[3] && vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/pic_priority.sv
// pic_priority: combinational rotating-priority resolver.
//   req         in  8 : pending, unmasked requests (IRR & ~IMR)
//   isr         in  8 : in-service register
//   lowest      in  3 : level currently holding lowest priority
//   win_idx     out 3 : highest-priority pending request
//   win_valid   out 1 : at least one request pending
//   isr_blocked out 1 : an in-service level at or above win_idx blocks it
module pic_priority
  import pic_pkg::*;
(
  input  logic [7:0] req,
  input  logic [7:0] isr,
  input  logic [2:0] lowest,
  output logic [2:0] win_idx,
  output logic       win_valid,
  output logic       isr_blocked
);

  logic [2:0] idx;
  logic       isr_seen;

  // Walk levels from highest to lowest priority; an in-service bit at the
  // same level as the winner also blocks it, so ISR is checked before req.
  always_comb begin
    win_idx     = 3'd0;
    win_valid   = 1'b0;
    isr_blocked = 1'b0;
    isr_seen    = 1'b0;
    idx         = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = lowest + 3'(i + 1);
      if (!win_valid) begin
        if (isr[idx]) isr_seen = 1'b1;
        if (req[idx]) begin
          win_valid   = 1'b1;
          win_idx     = idx;
          isr_blocked = isr_seen;
        end
      end
    end
  end

endmodule

// File: rtl/pic_8259a.sv
// pic_8259a: 8259A-style programmable interrupt controller.
//   clk, rst_n   : clock, synchronous active-low reset
//   CS, WR, RD   : active-low chip select / write / read strobes
//   A0           : register select
//   IR[7:0]      : interrupt requests (IR0 highest by default)
//   INTA         : interrupt acknowledge (active high, two pulses)
//   SP_EN        : 1 = master, 0 = slave
//   D[7:0]       : bidirectional data bus (read data, interrupt vector)
//   CAS[2:0]     : cascade ID bus (driven by a cascaded master)
//   INT          : interrupt request to the CPU
//
// Init sequencer
//   state      | meaning
//   INIT_READY | normal operation, OCWs accepted
//   INIT_ICW2  | waiting for vector base
//   INIT_ICW3  | waiting for slave map / slave ID
//   INIT_ICW4  | waiting for mode word (AEOI)
//
// INTA phase
//   state   | meaning
//   PH_IDLE | no acknowledge in progress, INT may assert
//   PH_ACK1 | first INTA seen, winner latched in cur_q
//   PH_ACK2 | second INTA high, vector presented on D
module pic_8259a
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CS,
  input  logic       WR,
  input  logic       RD,
  input  logic       A0,
  input  logic [7:0] IR,
  input  logic       INTA,
  input  logic       SP_EN,
  inout  wire  [7:0] D,
  inout  wire  [2:0] CAS,
  output logic       INT
);

  logic        wr_act_q, wr_act_d;
  logic        inta_q, inta_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  irr_q, irr_d;
  logic [7:0]  isr_q, isr_d;
  logic [7:0]  imr_q, imr_d;
  logic        int_q, int_d;
  init_state_e init_q, init_d;
  inta_phase_e phase_q, phase_d;
  logic [2:0]  cur_q, cur_d;
  logic        spur_q, spur_d;
  logic [4:0]  base_q, base_d;
  logic [2:0]  id_q, id_d;
  logic [7:0]  smap_q, smap_d;
  logic        sngl_q, sngl_d;
  logic        ic4_q, ic4_d;
  logic        ltim_q, ltim_d;
  logic        aeoi_q, aeoi_d;
  logic        rr_isr_q, rr_isr_d;
  logic [2:0]  lowest_q, lowest_d;

  logic        wr_act, wr_stb, rd_act;
  logic        inta_rise, inta_fall;
  logic        is_icw1;
  logic [7:0]  d_in;
  logic [7:0]  req_vec;
  logic [2:0]  win_idx;
  logic        win_valid, win_blocked, win_ok;
  logic [3:0]  eoi_sel;
  logic [7:0]  ack_clr;
  logic        cas_drive, vec_ok, vec_drive, d_oe;
  logic [7:0]  d_out;

  assign d_in      = D;
  assign wr_act    = !CS && !WR;
  assign wr_stb    = wr_act && !wr_act_q;
  assign rd_act    = !CS && !RD;
  assign inta_rise = INTA && !inta_q;
  assign inta_fall = !INTA && inta_q;
  assign is_icw1   = wr_stb && (A0 == ADDR_CMD) && d_in[4];
  assign req_vec   = irr_q & ~imr_q;
  assign win_ok    = win_valid && !win_blocked;
  assign eoi_sel   = top_isr(isr_q, lowest_q);

  pic_priority u_prio (
    .req         (req_vec),
    .isr         (isr_q),
    .lowest      (lowest_q),
    .win_idx     (win_idx),
    .win_valid   (win_valid),
    .isr_blocked (win_blocked)
  );

  always_comb begin
    wr_act_d = wr_act;
    inta_d   = INTA;
    ir_d     = IR;
    irr_d    = irr_q;
    isr_d    = isr_q;
    imr_d    = imr_q;
    init_d   = init_q;
    phase_d  = phase_q;
    cur_d    = cur_q;
    spur_d   = spur_q;
    base_d   = base_q;
    id_d     = id_q;
    smap_d   = smap_q;
    sngl_d   = sngl_q;
    ic4_d    = ic4_q;
    ltim_d   = ltim_q;
    aeoi_d   = aeoi_q;
    rr_isr_d = rr_isr_q;
    lowest_d = lowest_q;
    ack_clr  = 8'h00;

    // Register writes. ICW1 is recognised in any init state.
    if (is_icw1) begin
      imr_d    = 8'h00;
      isr_d    = 8'h00;
      lowest_d = FIXED_LOWEST;
      aeoi_d   = 1'b0;
      ic4_d    = d_in[0];
      sngl_d   = d_in[1];
      ltim_d   = d_in[3];
      init_d   = INIT_ICW2;
    end else if (wr_stb && (A0 == ADDR_DATA)) begin
      case (init_q)
        INIT_ICW2: begin
          base_d = d_in[7:3];
          if (!sngl_q)    init_d = INIT_ICW3;
          else if (ic4_q) init_d = INIT_ICW4;
          else            init_d = INIT_READY;
        end
        INIT_ICW3: begin
          if (SP_EN) smap_d = d_in;
          else       id_d   = d_in[2:0];
          init_d = ic4_q ? INIT_ICW4 : INIT_READY;
        end
        INIT_ICW4: begin
          aeoi_d = d_in[1];
          init_d = INIT_READY;
        end
        default: imr_d = d_in;
      endcase
    end else if (wr_stb && (init_q == INIT_READY)) begin
      if (d_in[4:3] == CMD_OCW2) begin
        case (d_in[7:5])
          OCW2_NS_EOI: begin
            if (eoi_sel[3]) isr_d[eoi_sel[2:0]] = 1'b0;
          end
          OCW2_ROT_NS_EOI: begin
            if (eoi_sel[3]) begin
              isr_d[eoi_sel[2:0]] = 1'b0;
              lowest_d = eoi_sel[2:0];
            end
          end
          OCW2_SP_EOI: isr_d[d_in[2:0]] = 1'b0;
          default: ;
        endcase
      end else if (d_in[4:3] == CMD_OCW3) begin
        if (d_in[1]) rr_isr_d = d_in[0];
      end
    end

    // Acknowledge sequencing; an ICW1 write abandons any cycle in flight.
    if (is_icw1) begin
      phase_d = PH_IDLE;
      spur_d  = 1'b0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (inta_rise) begin
            phase_d = PH_ACK1;
            if (win_ok) begin
              cur_d            = win_idx;
              spur_d           = 1'b0;
              isr_d[win_idx]   = 1'b1;
              ack_clr[win_idx] = 1'b1;
            end else begin
              // Nothing eligible: answer with the IR7 spurious vector.
              cur_d  = SPURIOUS_IR;
              spur_d = 1'b1;
            end
          end
        end
        PH_ACK1: begin
          if (inta_rise) phase_d = PH_ACK2;
        end
        PH_ACK2: begin
          if (inta_fall) begin
            phase_d = PH_IDLE;
            if (aeoi_q && !spur_q) isr_d[cur_q] = 1'b0;
          end
        end
        default: phase_d = PH_IDLE;
      endcase
    end

    // Arbitration reads irr_q, so an edge captured at the acknowledge edge
    // only competes in the next cycle.
    if (is_icw1)     irr_d = 8'h00;
    else if (ltim_q) irr_d = IR;
    else             irr_d = (irr_q & ~ack_clr) | (IR & ~ir_q);

    int_d = (init_q == INIT_READY) && (phase_q == PH_IDLE) && !inta_rise &&
            !is_icw1 && win_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_act_q <= 1'b0;
      inta_q   <= 1'b0;
      ir_q     <= 8'h00;
      irr_q    <= 8'h00;
      isr_q    <= 8'h00;
      imr_q    <= 8'h00;
      int_q    <= 1'b0;
      init_q   <= INIT_READY;
      phase_q  <= PH_IDLE;
      cur_q    <= 3'd0;
      spur_q   <= 1'b0;
      base_q   <= 5'd0;
      id_q     <= 3'd0;
      smap_q   <= 8'h00;
      sngl_q   <= 1'b1;
      ic4_q    <= 1'b0;
      ltim_q   <= 1'b0;
      aeoi_q   <= 1'b0;
      rr_isr_q <= 1'b0;
      lowest_q <= FIXED_LOWEST;
    end else begin
      wr_act_q <= wr_act_d;
      inta_q   <= inta_d;
      ir_q     <= ir_d;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      imr_q    <= imr_d;
      int_q    <= int_d;
      init_q   <= init_d;
      phase_q  <= phase_d;
      cur_q    <= cur_d;
      spur_q   <= spur_d;
      base_q   <= base_d;
      id_q     <= id_d;
      smap_q   <= smap_d;
      sngl_q   <= sngl_d;
      ic4_q    <= ic4_d;
      ltim_q   <= ltim_d;
      aeoi_q   <= aeoi_d;
      rr_isr_q <= rr_isr_d;
      lowest_q <= lowest_d;
    end
  end

  // Cascade master owns CAS from the first acknowledge until the second ends.
  assign cas_drive = SP_EN && !sngl_q && (phase_q != PH_IDLE) && !spur_q && smap_q[cur_q];

  // Who supplies the vector: a single device always; a master only for its
  // own (non-slave) inputs; a slave only when the master addresses its ID.
  always_comb begin
    if (sngl_q)     vec_ok = 1'b1;
    else if (SP_EN) vec_ok = !smap_q[cur_q];
    else            vec_ok = (CAS == id_q);
  end

  assign vec_drive = (phase_q == PH_ACK2) && INTA && vec_ok;
  assign d_oe      = vec_drive || rd_act;
  assign d_out     = vec_drive ? {base_q, cur_q} :
                     (A0 == ADDR_DATA) ? imr_q :
                     rr_isr_q ? isr_q : irr_q;

  assign D   = d_oe ? d_out : 8'bzzzz_zzzz;
  assign CAS = cas_drive ? cur_q : 3'bzzz;
  assign INT = int_q;

endmodule

// File: tb/tb_pic_8259a.sv
// Scoreboard bench for pic_8259a. Stimulus pushes expected values onto a
// queue; the monitor pops and compares when a sample point is signalled.
// D and CAS carry pull-ups, so an undriven bus reads as all ones.
module tb_pic_8259a;

  localparam int K_INT = 0;
  localparam int K_D   = 1;
  localparam int K_CAS = 2;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, CS, WR, RD, A0, INTA, SP_EN;
  logic [7:0] IR;
  wire  [7:0] D;
  wire  [2:0] CAS;
  logic       INT;

  logic [7:0] tb_d;
  logic       tb_d_oe;
  logic [2:0] tb_cas;
  logic       tb_cas_oe;

  exp_t sb[$];
  event chk_ev;
  int   total  = 0;
  int   bad    = 0;
  int   queued = 0;

  assign D   = tb_d_oe   ? tb_d   : 8'bzzzz_zzzz;
  assign CAS = tb_cas_oe ? tb_cas : 3'bzzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu_d
    pullup pu_d (D[g]);
  end
  for (genvar g = 0; g < 3; g++) begin : g_pu_cas
    pullup pu_cas (CAS[g]);
  end

  always #10 clk = ~clk;

  pic_8259a dut (
    .clk   (clk),
    .rst_n (rst_n),
    .CS    (CS),
    .WR    (WR),
    .RD    (RD),
    .A0    (A0),
    .IR    (IR),
    .INTA  (INTA),
    .SP_EN (SP_EN),
    .D     (D),
    .CAS   (CAS),
    .INT   (INT)
  );

  // Monitor: compares every queued expectation against the live outputs.
  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          K_INT:   act = {7'b0, INT};
          K_D:     act = D;
          default: act = {5'b0, CAS};
        endcase
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %02h want %02h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input logic [7:0] exp, input string name);
    exp_t e;
    #1;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    queued++;
    ->chk_ev;
    #1;
  endtask

  task automatic wr(input logic a0, input logic [7:0] data);
    CS = 1'b0; WR = 1'b0; A0 = a0; tb_d = data; tb_d_oe = 1'b1;
    cyc(1);
    CS = 1'b1; WR = 1'b1; tb_d_oe = 1'b0;
    cyc(1);
  endtask

  task automatic rd_chk(input logic a0, input logic [7:0] exp, input string name);
    CS = 1'b0; RD = 1'b0; A0 = a0;
    expect_v(K_D, exp, name);
    CS = 1'b1; RD = 1'b1;
    cyc(1);
  endtask

  task automatic inta_pulse();
    INTA = 1'b1; cyc(1);
    INTA = 1'b0; cyc(1);
  endtask

  task automatic inta_vec(input logic [7:0] exp, input string name);
    INTA = 1'b1; cyc(1);
    expect_v(K_D, exp, name);
    INTA = 1'b0; cyc(1);
  endtask

  // Bounded wait for INT; an expired bound shows up as a failed INT check.
  task automatic wait_int(input string name);
    for (int k = 0; k < 20 && INT !== 1'b1; k++) cyc(1);
    expect_v(K_INT, 8'h01, name);
  endtask

  initial begin : stim
    rst_n = 1'b0; CS = 1'b1; WR = 1'b1; RD = 1'b1; A0 = 1'b0;
    INTA = 1'b0; SP_EN = 1'b1; IR = 8'h00;
    tb_d = 8'h00; tb_d_oe = 1'b0; tb_cas = 3'd0; tb_cas_oe = 1'b0;
    cyc(3);
    expect_v(K_INT, 8'h00, "rst_int");
    expect_v(K_D,   8'hFF, "rst_d_hiz");
    expect_v(K_CAS, 8'h07, "rst_cas_hiz");
    rst_n = 1'b1;
    cyc(1);

    // Single, level-triggered, AEOI; IR7 masked.
    wr(1'b0, 8'h1B); wr(1'b1, 8'hA8); wr(1'b1, 8'h02); wr(1'b1, 8'h80);
    IR = 8'h08;
    cyc(2);
    expect_v(K_INT, 8'h01, "aeoi_int");
    INTA = 1'b1; cyc(1);
    expect_v(K_INT, 8'h00, "aeoi_int_drop");
    expect_v(K_CAS, 8'h07, "single_cas_hiz");
    INTA = 1'b0; cyc(1);
    wr(1'b0, 8'h0B);
    rd_chk(1'b0, 8'h08, "aeoi_isr_ack1");
    inta_vec(8'hAB, "aeoi_vector");
    IR = 8'h00;
    rd_chk(1'b0, 8'h00, "aeoi_isr_cleared");

    // Masking.
    IR = 8'h80;
    cyc(3);
    expect_v(K_INT, 8'h00, "masked_int");
    wr(1'b1, 8'h00);
    expect_v(K_INT, 8'h01, "unmasked_int");

    // Register reads.
    wr(1'b0, 8'h0A);
    rd_chk(1'b0, 8'h80, "read_irr");
    rd_chk(1'b1, 8'h00, "read_imr0");
    wr(1'b1, 8'h5A);
    rd_chk(1'b1, 8'h5A, "read_imr5a");
    IR = 8'h00;
    cyc(2);

    // Nested priority, edge mode, normal EOI, rotation.
    wr(1'b0, 8'h13); wr(1'b1, 8'h20); wr(1'b1, 8'h00);
    IR = 8'h0A;
    cyc(2);
    expect_v(K_INT, 8'h01, "nest_int");
    inta_pulse();
    inta_vec(8'h21, "nest_vec_ir1");
    wr(1'b0, 8'h0B);
    rd_chk(1'b0, 8'h02, "nest_isr_ir1");
    expect_v(K_INT, 8'h00, "nest_ir3_blocked");
    wr(1'b0, 8'h20);
    expect_v(K_INT, 8'h01, "nest_int_after_eoi");
    rd_chk(1'b0, 8'h00, "nest_isr_after_eoi");
    inta_pulse();
    inta_vec(8'h23, "nest_vec_ir3");
    rd_chk(1'b0, 8'h08, "nest_isr_ir3");
    wr(1'b0, 8'hA0);
    rd_chk(1'b0, 8'h00, "rot_isr_cleared");
    IR = 8'h00; cyc(1);
    IR = 8'h12;
    cyc(2);
    expect_v(K_INT, 8'h01, "rot_int");
    inta_pulse();
    inta_vec(8'h24, "rot_vec_ir4");
    wr(1'b0, 8'h64);
    rd_chk(1'b0, 8'h00, "sp_eoi_isr");
    IR = 8'h00;
    cyc(2);

    // Slave, ID 2.
    SP_EN = 1'b0;
    wr(1'b0, 8'h19); wr(1'b1, 8'hA9); wr(1'b1, 8'h02); wr(1'b1, 8'h02);
    tb_cas = 3'd2; tb_cas_oe = 1'b1;
    IR = 8'h04;
    wait_int("slave_int");
    inta_pulse();
    inta_vec(8'hAA, "slave_vec_match");
    tb_cas = 3'd3;
    wait_int("slave_int_again");
    inta_pulse();
    inta_vec(8'hFF, "slave_vec_other_id");
    IR = 8'h00; tb_cas_oe = 1'b0; SP_EN = 1'b1;
    cyc(2);

    // Cascade master, slave on IR2.
    wr(1'b0, 8'h11); wr(1'b1, 8'h40); wr(1'b1, 8'h04); wr(1'b1, 8'h00);
    IR = 8'h04;
    cyc(2);
    expect_v(K_INT, 8'h01, "master_int");
    INTA = 1'b1; cyc(1);
    expect_v(K_CAS, 8'h02, "master_cas_ack1");
    INTA = 1'b0; cyc(1);
    INTA = 1'b1; cyc(1);
    expect_v(K_D,   8'hFF, "master_no_vec_for_slave");
    expect_v(K_CAS, 8'h02, "master_cas_ack2");
    INTA = 1'b0; cyc(1);
    expect_v(K_CAS, 8'h07, "master_cas_released");
    wr(1'b0, 8'h20);
    IR = 8'h05;
    wait_int("master_int_ir0");
    INTA = 1'b1; cyc(1);
    expect_v(K_CAS, 8'h07, "master_cas_nonslave");
    INTA = 1'b0; cyc(1);

    // Reset between the two acknowledge pulses.
    IR = 8'h00;
    rst_n = 1'b0;
    cyc(1);
    expect_v(K_INT, 8'h00, "midrst_int");
    expect_v(K_D,   8'hFF, "midrst_d_hiz");
    expect_v(K_CAS, 8'h07, "midrst_cas_hiz");
    rst_n = 1'b1;
    cyc(1);
    wr(1'b0, 8'h0B);
    rd_chk(1'b0, 8'h00, "midrst_isr");
    inta_vec(8'hFF, "midrst_no_vector");
    inta_vec(8'h07, "spurious_ir7");

    cyc(2);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d expectations never compared", sb.size());
    end
    if (total != queued) begin
      bad++;
      $display("FAIL scoreboard: compared %0d of %0d queued", total, queued);
    end
    if (bad != 0) $display("FAIL test: total=%0d bad=%0d", total, bad);
    else          $display("PASS test: total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
